// File: rtl/commit_unit.sv
// In-order retirement stage: pops the ROB tail, writes the register file, releases stores, flushes on mispredict.
// Optional COMMIT_STATS_EN macro adds saturating retire/flush counters.
module commit_unit #(
  parameter int ROB_DEPTH     = 4,
  parameter int STORE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rob_valid,
  input  logic                 rob_ready,
  input  logic [4:0]           commit_rd_s,
  input  logic [31:0]          commit_rd_v,
  input  logic [ROB_DEPTH-1:0] commit_rob,
  input  logic [6:0]           commit_opcode,
  input  logic [31:0]          commit_pc,
  input  logic                 flush_branch,
  input  logic [31:0]          pc_branch_target,
  input  logic [63:0]          order_branch_target,
  input  logic                 store_done,
  output logic                 rob_pop,
  output logic                 regfile_we,
  output logic [4:0]           regfile_rd_s,
  output logic [31:0]          regfile_rd_v,
  output logic [ROB_DEPTH-1:0] regfile_rob,
  output logic                 store_commit,
  output logic                 move_flush,
  output logic [31:0]          redirect_pc,
  output logic [63:0]          redirect_order,
  output logic [63:0]          commit_order,
  output logic                 store_hang,
  output logic [31:0]          stat_commits,
  output logic [31:0]          stat_flushes
);

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int             CNT_W        = $clog2(STORE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(STORE_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STORE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STORE_REQ, STORE_WAIT, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [31:0]      target_pc_reg;
  logic [63:0]      target_order_reg;
  logic [63:0]      order_reg;
  logic             hang_reg;
  logic             latch_flush;
  logic             take, is_store, is_branch, is_ctrl;

  // The retiring PC is carried for tracing only; nothing in retirement depends on it.
  logic unused_pc;
  assign unused_pc = ^commit_pc;

  assign take      = rob_valid && rob_ready;
  assign is_store  = (commit_opcode == OP_STORE);
  assign is_branch = (commit_opcode == OP_BRANCH);
  assign is_ctrl   = is_branch || (commit_opcode == OP_JAL) || (commit_opcode == OP_JALR);

  assign regfile_rd_s   = commit_rd_s;
  assign regfile_rd_v   = commit_rd_v;
  assign regfile_rob    = commit_rob;
  assign redirect_pc    = target_pc_reg;
  assign redirect_order = target_order_reg;
  assign commit_order   = order_reg;
  assign store_hang     = hang_reg;

  always_comb begin
    state_next   = state_reg;
    rob_pop      = 1'b0;
    regfile_we   = 1'b0;
    store_commit = 1'b0;
    move_flush   = 1'b0;
    latch_flush  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (take) begin
          if (is_store) begin
            state_next = STORE_REQ;
          end else begin
            rob_pop    = 1'b1;
            regfile_we = (commit_rd_s != 5'd0) && !is_branch;
            if (is_ctrl && flush_branch) begin
              latch_flush = 1'b1;
              state_next  = FLUSH;
            end
          end
        end
      end
      STORE_REQ: begin
        store_commit = 1'b1;
        state_next   = STORE_WAIT;
      end
      STORE_WAIT: begin
        if (store_done) begin
          rob_pop    = 1'b1;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        move_flush = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      wait_cnt_reg     <= '0;
      target_pc_reg    <= '0;
      target_order_reg <= '0;
      order_reg        <= '0;
      hang_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Loading the restart order at the pop makes it visible during the flush cycle.
      if (latch_flush) begin
        target_pc_reg    <= pc_branch_target;
        target_order_reg <= order_branch_target;
        order_reg        <= order_branch_target;
      end else if (move_flush) begin
        order_reg <= target_order_reg;
      end else if (rob_pop) begin
        order_reg <= order_reg + 64'd1;
      end
      if (state_reg == STORE_REQ) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == STORE_WAIT && !store_done) begin
        if (wait_cnt_reg != CNT_MAX) wait_cnt_reg <= wait_cnt_reg + 1'b1;
        if (wait_cnt_reg >= TIMEOUT_LAST) hang_reg <= 1'b1;
      end
    end
  end

`ifdef COMMIT_STATS_EN
  logic [31:0] commits_reg, flushes_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      commits_reg <= '0;
      flushes_reg <= '0;
    end else begin
      if (rob_pop && commits_reg != 32'hFFFF_FFFF) commits_reg <= commits_reg + 32'd1;
      if (move_flush && flushes_reg != 32'hFFFF_FFFF) flushes_reg <= flushes_reg + 32'd1;
    end
  end

  assign stat_commits = commits_reg;
  assign stat_flushes = flushes_reg;
`else
  assign stat_commits = '0;
  assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Randomized bench for commit_unit against a transaction-level retirement model.
// Builds with or without COMMIT_STATS_EN.
module tb_commit_unit;

  localparam int TMO = 4;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic        clk, rst;
  logic        rob_valid, rob_ready, flush_branch, store_done;
  logic [4:0]  commit_rd_s;
  logic [31:0] commit_rd_v, commit_pc, pc_branch_target;
  logic [3:0]  commit_rob;
  logic [6:0]  commit_opcode;
  logic [63:0] order_branch_target;
  logic        rob_pop, regfile_we, store_commit, move_flush, store_hang;
  logic [4:0]  regfile_rd_s;
  logic [31:0] regfile_rd_v, redirect_pc, stat_commits, stat_flushes;
  logic [3:0]  regfile_rob;
  logic [63:0] redirect_order, commit_order;

  commit_unit #(.ROB_DEPTH(4), .STORE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_ready(rob_ready),
    .commit_rd_s(commit_rd_s), .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
    .commit_opcode(commit_opcode), .commit_pc(commit_pc), .flush_branch(flush_branch),
    .pc_branch_target(pc_branch_target), .order_branch_target(order_branch_target),
    .store_done(store_done), .rob_pop(rob_pop), .regfile_we(regfile_we),
    .regfile_rd_s(regfile_rd_s), .regfile_rd_v(regfile_rd_v), .regfile_rob(regfile_rob),
    .store_commit(store_commit), .move_flush(move_flush), .redirect_pc(redirect_pc),
    .redirect_order(redirect_order), .commit_order(commit_order), .store_hang(store_hang),
    .stat_commits(stat_commits), .stat_flushes(stat_flushes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [63:0] exp_order;
  logic [31:0] exp_commits, exp_flushes;
  logic        exp_hang;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_order"}, commit_order, exp_order);
    check({tag, "_hang"}, 64'(store_hang), 64'(exp_hang));
`ifdef COMMIT_STATS_EN
    check({tag, "_commits"}, 64'(stat_commits), 64'(exp_commits));
    check({tag, "_flushes"}, 64'(stat_flushes), 64'(exp_flushes));
`else
    check({tag, "_commits"}, 64'(stat_commits), 64'd0);
    check({tag, "_flushes"}, 64'(stat_flushes), 64'd0);
`endif
  endtask

  task automatic model_reset();
    exp_order = '0; exp_commits = '0; exp_flushes = '0; exp_hang = 1'b0;
  endtask

  task automatic drive_entry(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val,
                             input logic fl, input logic [31:0] tpc, input logic [63:0] tord);
    rob_valid = 1'b1; rob_ready = 1'b1;
    commit_opcode = op; commit_rd_s = rd; commit_rd_v = val; flush_branch = fl;
    commit_rob = 4'($urandom); commit_pc = $urandom;
    pc_branch_target = tpc; order_branch_target = tord;
  endtask

  // Non-store retirement, including mispredicted control transfers.
  task automatic retire_normal(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val,
                               input logic fl, input logic [31:0] tpc, input logic [63:0] tord);
    logic ctrl, mis, we;
    ctrl = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    mis  = ctrl && fl;
    we   = (rd != 5'd0) && (op != OP_BRANCH) && (op != OP_STORE);
    @(negedge clk);
    drive_entry(op, rd, val, fl, tpc, tord);
    store_done = 1'($urandom);
    #1;
    $display("retire op=%b rd=%0d val=0x%0h flush=%0d", op, rd, val, mis);
    check("pop", 64'(rob_pop), 64'd1);
    check("we", 64'(regfile_we), 64'(we));
    check("rd_s", 64'(regfile_rd_s), 64'(rd));
    check("rd_v", 64'(regfile_rd_v), 64'(val));
    check("rob", 64'(regfile_rob), 64'(commit_rob));
    check("no_flush_n", 64'(move_flush), 64'd0);
    check("no_sc_n", 64'(store_commit), 64'd0);
    exp_commits++;
    if (mis) exp_order = tord; else exp_order = exp_order + 64'd1;
    @(negedge clk);
    rob_valid = 1'b0;
    #1;
    if (mis) begin
      check("flush", 64'(move_flush), 64'd1);
      check("redir_pc", 64'(redirect_pc), 64'(tpc));
      check("redir_ord", redirect_order, tord);
      check("flush_pop", 64'(rob_pop), 64'd0);
      check("flush_order", commit_order, tord);
      exp_flushes++;
      @(negedge clk);
      #1;
      check("flush_end", 64'(move_flush), 64'd0);
    end else begin
      check("no_flush", 64'(move_flush), 64'd0);
    end
    check_regs("post");
  endtask

  // Store: done arrives d cycles after the store_commit cycle (d >= 1).
  task automatic retire_store(input int d, input logic [4:0] rd);
    int nodone;
    @(negedge clk);
    drive_entry(OP_STORE, rd, $urandom, 1'($urandom), $urandom, {$urandom, $urandom});
    store_done = 1'($urandom);
    #1;
    $display("store rd=%0d done_delay=%0d", rd, d);
    check("st_pop0", 64'(rob_pop), 64'd0);
    check("st_we", 64'(regfile_we), 64'd0);
    check("st_sc0", 64'(store_commit), 64'd0);
    @(negedge clk);
    store_done = 1'($urandom);
    #1;
    check("st_sc", 64'(store_commit), 64'd1);
    check("st_pop1", 64'(rob_pop), 64'd0);
    nodone = 0;
    for (int i = 1; i < d; i++) begin
      @(negedge clk);
      store_done = 1'b0;
      #1;
      check("st_wait_sc", 64'(store_commit), 64'd0);
      check("st_wait_pop", 64'(rob_pop), 64'd0);
      check("st_wait_hang", 64'(store_hang), 64'(exp_hang || nodone >= TMO));
      nodone++;
    end
    @(negedge clk);
    store_done = 1'b1;
    #1;
    check("st_done_pop", 64'(rob_pop), 64'd1);
    check("st_done_sc", 64'(store_commit), 64'd0);
    check("st_done_hang", 64'(store_hang), 64'(exp_hang || nodone >= TMO));
    if (nodone >= TMO) exp_hang = 1'b1;
    exp_order = exp_order + 64'd1;
    exp_commits++;
    @(negedge clk);
    rob_valid = 1'b0; store_done = 1'b0;
    #1;
    check("st_after_pop", 64'(rob_pop), 64'd0);
    check_regs("st_post");
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rob_valid = 1'($urandom); rob_ready = 1'b0;
    commit_rd_s = 5'($urandom); commit_rd_v = $urandom;
    store_done = 1'($urandom);
    #1;
    $display("idle valid=%0d", rob_valid);
    check("idle_pop", 64'(rob_pop), 64'd0);
    check("idle_we", 64'(regfile_we), 64'd0);
    check("idle_rd_v", 64'(regfile_rd_v), 64'(commit_rd_v));
    check("idle_flush", 64'(move_flush), 64'd0);
    rob_valid = 1'b0;
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    drive_entry(OP_STORE, 5'd3, 32'h55, 1'b0, 32'd0, 64'd0);
    store_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rob_valid = 1'b0; store_done = 1'b1;
    model_reset();
    #1;
    $display("reset during store wait");
    check("rw_pop", 64'(rob_pop), 64'd0);
    check("rw_sc", 64'(store_commit), 64'd0);
    check("rw_flush", 64'(move_flush), 64'd0);
    check("rw_redir", 64'(redirect_pc), 64'd0);
    check_regs("rw");
    @(negedge clk);
    #1;
    check("rw_late_pop", 64'(rob_pop), 64'd0);
    check("rw_late_sc", 64'(store_commit), 64'd0);
    store_done = 1'b0;
  endtask

  logic [6:0] ops [0:6];

  initial begin
    ops[0] = OP_ALU; ops[1] = OP_IMM; ops[2] = OP_LOAD; ops[3] = OP_LUI;
    ops[4] = OP_BRANCH; ops[5] = OP_JAL; ops[6] = OP_JALR;
    rst = 1'b1; rob_valid = 1'b0; rob_ready = 1'b0; flush_branch = 1'b0; store_done = 1'b0;
    commit_rd_s = '0; commit_rd_v = '0; commit_rob = '0; commit_opcode = '0; commit_pc = '0;
    pc_branch_target = '0; order_branch_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset state");
    check("rst_pop", 64'(rob_pop), 64'd0);
    check("rst_sc", 64'(store_commit), 64'd0);
    check("rst_flush", 64'(move_flush), 64'd0);
    check("rst_redir_ord", redirect_order, 64'd0);
    check_regs("rst");

    retire_normal(OP_ALU, 5'd5, 32'h1234, 1'b0, 32'd0, 64'd0);
    retire_normal(OP_ALU, 5'd0, 32'hDEAD, 1'b0, 32'd0, 64'd0);
    retire_normal(OP_BRANCH, 5'd7, 32'h1, 1'b0, 32'h40, 64'h99);
    retire_store(3, 5'd2);
    retire_normal(OP_JAL, 5'd1, 32'h104, 1'b1, 32'h200, 64'h10);
    retire_store(6, 5'd4);
    retire_normal(OP_JALR, 5'd9, 32'h8, 1'b1, 32'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    retire_normal(OP_LOAD, 5'd10, 32'h77, 1'b0, 32'd0, 64'd0);
    reset_in_wait();

    for (int t = 0; t < 150; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) idle_cycle();
      else if (kind < 4) retire_store($urandom_range(1, 6), 5'($urandom));
      else retire_normal(ops[$urandom_range(0, 6)], 5'($urandom), $urandom, 1'($urandom),
                         $urandom, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage directly downstream of the reorder buffer. Each cycle it inspects the ROB tail entry, retires it when ready, and performs the entry's architectural side effects: the register-file/RAT write, the store release to the store queue, and the mispredict flush with fetch redirect. It owns the `rob_pop` and `move_flush` signals for the whole out-of-order core.

## Interface
Parameters:
- ROB_DEPTH, 4, index width of ROB entries
- STORE_TIMEOUT, 255, max cycles waiting on `store_done` before `store_hang` asserts

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rob_valid  in  1  tail entry occupied
- rob_ready  in  1  tail entry result ready
- commit_rd_s  in  5  tail destination register
- commit_rd_v  in  32  tail result
- commit_rob  in  ROB_DEPTH  tail ROB index
- commit_opcode  in  7  tail opcode
- commit_pc  in  32  tail PC
- flush_branch  in  1  tail branch mispredicted
- pc_branch_target  in  32  corrected next PC
- order_branch_target  in  64  order of the first post-flush instruction
- store_done  in  1  store queue finished the committed store
- rob_pop  out  1  retire the tail this cycle
- regfile_we  out  1  architectural write enable
- regfile_rd_s  out  5  write address
- regfile_rd_v  out  32  write data
- regfile_rob  out  ROB_DEPTH  ROB tag, used by the RAT to clear its mapping
- store_commit  out  1  release the head store to memory (one-cycle pulse)
- move_flush  out  1  global pipeline flush (one-cycle pulse)
- redirect_pc  out  32  fetch restart PC, valid with `move_flush`
- redirect_order  out  64  rvfi order restart, valid with `move_flush`
- commit_order  out  64  order of the next instruction to retire
- store_hang  out  1  sticky: store timeout occurred
- stat_commits  out  32  retired count (COMMIT_STATS_EN only)
- stat_flushes  out  32  flush count (COMMIT_STATS_EN only)

## Operation
- FSM states: IDLE, STORE_REQ, STORE_WAIT, FLUSH.
- **IDLE**, when `rob_valid && rob_ready`:
  - Non-store, non-mispredict: `rob_pop=1` combinationally. `regfile_we=1` iff `commit_rd_s!=0` and the opcode is not branch or store. `commit_order` increments.
  - Store opcode (7'b0100011): no pop. Go to STORE_REQ.
  - jal, jalr or branch with `flush_branch=1`: pop and regfile write as for a normal entry. Latch `pc_branch_target` and `order_branch_target`. Go to FLUSH.
- **STORE_REQ**: `store_commit=1` for one cycle, then go to STORE_WAIT. The timeout counter is cleared here.
- **STORE_WAIT**: on `store_done`, `rob_pop=1` that cycle, increment `commit_order`, return to IDLE.
  - The counter increments each cycle without `store_done`.
  - At STORE_TIMEOUT, set `store_hang` (sticky until rst). Keep waiting.
- **FLUSH**: `move_flush=1`, `redirect_pc`/`redirect_order` driven from the latches. `commit_order` loads the latched order. No pop. Next state is IDLE.
- `regfile_*` outputs mirror the tail fields every cycle. Only `regfile_we` is gated.
- Outputs held at reset: state IDLE; `rob_pop`, `regfile_we`, `store_commit`, `move_flush`, `store_hang` = 0; `commit_order`, `redirect_*`, stats = 0.

## Timing
- Non-store retirement: 0-cycle decision. At most one retire per cycle.
- Store retirement: request in cycle N+1, pop no earlier than N+2 (`store_done` may arrive in N+2).
- Mispredict: pop in cycle N, `move_flush` in N+1, IDLE in N+2. The ROB is empty after N+1.
- `store_done` outside STORE_WAIT is ignored.
- `rst` in any state returns to IDLE next edge and drops any pending store or flush. A `rst` in the same cycle as FLUSH suppresses nothing already driven that cycle.
- 64-bit `commit_order` wraps modulo 2^64. The 32-bit stats counters saturate at 0xFFFFFFFF.

## Configuration
- COMMIT_STATS_EN:
  - Defined: `stat_commits` increments on every `rob_pop`; `stat_flushes` increments on every `move_flush`.
  - Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- ALU entry, rd=x5, value 0x1234, ready -> same cycle `rob_pop=1`, `regfile_we=1`, rd 5 value 0x1234, `commit_order` 0->1.
- Entry with rd=x0 -> pop=1, `regfile_we=0`. Branch entry with `flush_branch=0` -> pop=1, `regfile_we=0`, no flush.
- Store ready, `store_done` 3 cycles after `store_commit` -> `store_commit` single pulse; pop exactly once, in the `store_done` cycle; `commit_order` +1.
- jal rd=x1 value 0x104, `flush_branch=1`, target 0x200, order 0x10 -> pop + write x1 in N; N+1 `move_flush=1`, `redirect_pc=0x200`, `commit_order=0x10`, no pop.
- STORE_TIMEOUT=4 with `store_done` withheld -> `store_hang=1` after 4 wait cycles and held; later `store_done` -> pop; `store_hang` stays 1 until rst.
- `rst` asserted in STORE_WAIT -> next cycle IDLE, all outputs 0, late `store_done` causes no pop.
